wb_stage: RTL and testbench

- Writeback stage: holds the MEM/WB pipeline register and formats load data.
- Selects the result and arbitrates the single register-file write port (a3/wd3/we3) between the in-order pipeline and a long-latency unit (divider) return path.
- Long-latency results are buffered in a small FIFO and written only in cycles the pipeline does not use the port.

---
 rtl/riscv_pkg.sv | 14 +
 rtl/wb_ret_fifo.sv | 54 +++++
 rtl/wb_stage.sv | 112 +++++++++++
 tb/tb_wb_stage.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared writeback types, load funct3 codes and the long-latency return entry
package riscv_pkg;
  localparam int XLEN = 32;
  typedef enum logic [1:0] {RES_ALU = 2'b00, RES_LOAD = 2'b01, RES_PC4 = 2'b10} result_src_t;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } lu_entry_t;
endpackage

// File: rtl/wb_ret_fifo.sv
// wb_ret_fifo: sync FIFO of long-latency results; push ignored when full, pop ignored when empty
module wb_ret_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk_i,
  input  logic                   reset_ni,
  input  logic                   push_i,
  input  lu_entry_t              entry_i,
  input  logic                   pop_i,
  output lu_entry_t              head_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          push, pop;
  lu_entry_t     mem_q [DEPTH];

  assign full_o  = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_q];
  assign push    = push_i & !full_o;
  assign pop     = pop_i & !empty_o;

  // next pointers wrap naturally because DEPTH is a power of two
  always_comb begin
    wr_d  = push ? wr_q + AW'(1) : wr_q;
    rd_d  = pop ? rd_q + AW'(1) : rd_q;
    cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  end

  // pointer and occupancy state
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // storage needs no reset: occupancy qualifies every read
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_q] <= entry_i;
  end
endmodule

// File: rtl/wb_stage.sv
// wb_stage: MEM/WB register, load formatting and reg-file write-port arbitration.
// Optional WB_LU_BYPASS_EN lets a long-latency result write in its arrival cycle when the port and FIFO are idle.
module wb_stage
  import riscv_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int LQ_DEPTH = 2
) (
  input  logic                      clk_i,
  input  logic                      reset_ni,
  input  logic                      stall_i,
  input  logic                      flush_i,
  input  logic                      mem_valid_i,
  input  logic                      mem_we_i,
  input  logic [4:0]                mem_rd_i,
  input  logic [1:0]                mem_result_src_i,
  input  logic [2:0]                mem_funct3_i,
  input  logic [WIDTH-1:0]          mem_alu_result_i,
  input  logic [WIDTH-1:0]          mem_load_data_i,
  input  logic [WIDTH-1:0]          mem_pc_plus4_i,
  input  logic                      lu_valid_i,
  input  logic [4:0]                lu_rd_i,
  input  logic [WIDTH-1:0]          lu_data_i,
  output logic                      lu_ready_o,
  output logic [$clog2(LQ_DEPTH):0] lq_count_o,
  output logic [4:0]                a3_o,
  output logic [WIDTH-1:0]          wd3_o,
  output logic                      we3_o
);
  logic             valid_q, valid_d, done_q, done_d, we_q;
  logic [4:0]       rd_q;
  logic [1:0]       src_q;
  logic [2:0]       f3_q;
  logic [WIDTH-1:0] alu_q, ld_q, pc4_q, ld_fmt, result;
  logic [7:0]       b;
  logic [15:0]      h;
  logic             pw, deq, byp, full, empty;
  lu_entry_t        head, entry;

  assign pw  = valid_q & we_q & (rd_q != 5'd0) & !done_q;
  assign deq = !pw & !empty;
`ifdef WB_LU_BYPASS_EN
  assign byp = !pw & empty & lu_valid_i;
`else
  assign byp = 1'b0;
`endif
  assign lu_ready_o = !full;
  assign entry      = '{rd: lu_rd_i, data: XLEN'(lu_data_i)};

  // a held instruction writes once: done latches after its grant while stalled
  always_comb begin
    valid_d = stall_i ? valid_q & !flush_i : mem_valid_i & !flush_i;
    done_d  = stall_i & (done_q | pw);
  end

  // MEM/WB pipeline register
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
      rd_q    <= '0;
      src_q   <= '0;
      f3_q    <= '0;
      alu_q   <= '0;
      ld_q    <= '0;
      pc4_q   <= '0;
    end else begin
      valid_q <= valid_d;
      done_q  <= done_d;
      if (!stall_i) begin
        we_q  <= mem_we_i;
        rd_q  <= mem_rd_i;
        src_q <= mem_result_src_i;
        f3_q  <= mem_funct3_i;
        alu_q <= mem_alu_result_i;
        ld_q  <= mem_load_data_i;
        pc4_q <= mem_pc_plus4_i;
      end
    end
  end

  // load extraction by byte offset, then result select (reserved source falls back to ALU)
  always_comb begin
    b      = ld_q[{alu_q[1:0], 3'b000} +: 8];
    h      = ld_q[{alu_q[1], 4'b0000} +: 16];
    ld_fmt = f3_q == F3_LB  ? {{(WIDTH-8){b[7]}}, b} :
             f3_q == F3_LBU ? {{(WIDTH-8){1'b0}}, b} :
             f3_q == F3_LH  ? {{(WIDTH-16){h[15]}}, h} :
             f3_q == F3_LHU ? {{(WIDTH-16){1'b0}}, h} : ld_q;
    result = src_q == RES_LOAD ? ld_fmt : src_q == RES_PC4 ? pc4_q : alu_q;
  end

  // write port: pipeline first, then FIFO head, then optional same-cycle bypass
  always_comb begin
    a3_o  = pw ? rd_q : deq ? head.rd : byp ? lu_rd_i : 5'd0;
    wd3_o = pw ? result : deq ? WIDTH'(head.data) : byp ? lu_data_i : '0;
    we3_o = pw | (deq & (head.rd != 5'd0)) | (byp & (lu_rd_i != 5'd0));
  end

  wb_ret_fifo #(.DEPTH(LQ_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .reset_ni(reset_ni),
    .push_i  (lu_valid_i & !byp),
    .entry_i (entry),
    .pop_i   (deq),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (lq_count_o)
  );
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed vectors with hand-computed expectations for wb_stage
module tb_wb_stage;
  logic        clk_i = 1'b0, reset_ni = 1'b0, stall_i = 1'b0, flush_i = 1'b0;
  logic        mem_valid_i = 1'b0, mem_we_i = 1'b0;
  logic [4:0]  mem_rd_i = '0;
  logic [1:0]  mem_result_src_i = '0;
  logic [2:0]  mem_funct3_i = '0;
  logic [31:0] mem_alu_result_i = '0, mem_load_data_i = '0, mem_pc_plus4_i = '0;
  logic        lu_valid_i = 1'b0;
  logic [4:0]  lu_rd_i = '0;
  logic [31:0] lu_data_i = '0;
  logic        lu_ready_o, we3_o;
  logic [1:0]  lq_count_o;
  logic [4:0]  a3_o;
  logic [31:0] wd3_o;
  int          n_cmp = 0, n_err = 0;

  wb_stage dut (
    .clk_i(clk_i), .reset_ni(reset_ni), .stall_i(stall_i), .flush_i(flush_i),
    .mem_valid_i(mem_valid_i), .mem_we_i(mem_we_i), .mem_rd_i(mem_rd_i),
    .mem_result_src_i(mem_result_src_i), .mem_funct3_i(mem_funct3_i),
    .mem_alu_result_i(mem_alu_result_i), .mem_load_data_i(mem_load_data_i),
    .mem_pc_plus4_i(mem_pc_plus4_i), .lu_valid_i(lu_valid_i), .lu_rd_i(lu_rd_i),
    .lu_data_i(lu_data_i), .lu_ready_o(lu_ready_o), .lq_count_o(lq_count_o),
    .a3_o(a3_o), .wd3_o(wd3_o), .we3_o(we3_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic mem_op(input logic [4:0] rd, input logic [1:0] src, input logic [2:0] f3,
                        input logic [31:0] alu, input logic [31:0] ld, input logic [31:0] pc4);
    mem_valid_i = 1'b1; mem_we_i = 1'b1; mem_rd_i = rd; mem_result_src_i = src;
    mem_funct3_i = f3; mem_alu_result_i = alu; mem_load_data_i = ld; mem_pc_plus4_i = pc4;
  endtask

  task automatic lu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    lu_valid_i = v; lu_rd_i = rd; lu_data_i = d;
  endtask

  // one captured instruction, checked in its writeback cycle
  task automatic load_case(input string tag, input logic [1:0] src, input logic [2:0] f3,
                           input logic [31:0] alu, input logic [31:0] exp);
    mem_op(5'd3, src, f3, alu, 32'h80FF_7F01, 32'h0000_4004);
    tick();
    mem_valid_i = 1'b0;
    #1;
    chk({tag, "_we"}, {31'd0, we3_o}, 32'd1);
    chk({tag, "_wd"}, wd3_o, exp);
  endtask

  initial begin
    #3;
    chk("rst_we", {31'd0, we3_o}, 32'd0);
    chk("rst_a3", {27'd0, a3_o}, 32'd0);
    chk("rst_wd", wd3_o, 32'd0);
    chk("rst_rdy", {31'd0, lu_ready_o}, 32'd1);
    chk("rst_cnt", {30'd0, lq_count_o}, 32'd0);
    reset_ni = 1'b1;
    tick();

    load_case("lb", 2'b01, 3'b000, 32'h0000_1003, 32'hFFFF_FF80);
    load_case("lbu", 2'b01, 3'b100, 32'h0000_1003, 32'h0000_0080);
    load_case("lh2", 2'b01, 3'b001, 32'h0000_1002, 32'hFFFF_80FF);
    load_case("lhu3", 2'b01, 3'b101, 32'h0000_1003, 32'h0000_80FF);
    load_case("lb1", 2'b01, 3'b000, 32'h0000_1001, 32'h0000_007F);
    load_case("lw1", 2'b01, 3'b010, 32'h0000_1001, 32'h80FF_7F01);
    load_case("pc4", 2'b10, 3'b000, 32'h0000_1001, 32'h0000_4004);
    load_case("rsv", 2'b11, 3'b000, 32'h0000_1001, 32'h0000_1001);
    tick();
    chk("idle_we", {31'd0, we3_o}, 32'd0);

    // pipeline priority over a pending FIFO entry
    mem_op(5'd5, 2'b00, 3'b000, 32'h0000_1234, 32'h0, 32'h0);
    lu(1'b1, 5'd7, 32'h0000_00AB);
    tick();
    mem_valid_i = 1'b0; lu(1'b0, 5'd0, 32'h0);
    #1;
    chk("pri_a3", {27'd0, a3_o}, 32'd5);
    chk("pri_wd", wd3_o, 32'h0000_1234);
    chk("pri_cnt", {30'd0, lq_count_o}, 32'd1);
    tick();
    chk("deq_a3", {27'd0, a3_o}, 32'd7);
    chk("deq_wd", wd3_o, 32'h0000_00AB);
    chk("deq_we", {31'd0, we3_o}, 32'd1);
    tick();
    chk("deq_cnt0", {30'd0, lq_count_o}, 32'd0);
    chk("deq_we0", {31'd0, we3_o}, 32'd0);

    // held load writes once, FIFO drains under the stall
    mem_op(5'd9, 2'b01, 3'b010, 32'h0000_2000, 32'hCAFE_F00D, 32'h0);
    tick();
    mem_valid_i = 1'b0; stall_i = 1'b1; lu(1'b1, 5'd11, 32'h0000_0011);
    #1;
    chk("stl0_a3", {27'd0, a3_o}, 32'd9);
    chk("stl0_wd", wd3_o, 32'hCAFE_F00D);
    tick();
    lu(1'b0, 5'd0, 32'h0);
    #1;
    chk("stl1_a3", {27'd0, a3_o}, 32'd11);
    chk("stl1_wd", wd3_o, 32'h0000_0011);
    chk("stl1_cnt", {30'd0, lq_count_o}, 32'd1);
    tick();
    chk("stl2_we", {31'd0, we3_o}, 32'd0);
    chk("stl2_cnt", {30'd0, lq_count_o}, 32'd0);
    tick();
    chk("stl3_we", {31'd0, we3_o}, 32'd0);
    stall_i = 1'b0;
    tick();

    // three back-to-back results against a busy pipeline
    mem_op(5'd1, 2'b00, 3'b000, 32'h1, 32'h0, 32'h0);
    lu(1'b1, 5'd20, 32'hA0);
    tick();
    mem_op(5'd2, 2'b00, 3'b000, 32'h2, 32'h0, 32'h0);
    lu(1'b1, 5'd21, 32'hB0);
    #1;
    chk("bb0_a3", {27'd0, a3_o}, 32'd1);
    tick();
    mem_op(5'd3, 2'b00, 3'b000, 32'h3, 32'h0, 32'h0);
    lu(1'b1, 5'd22, 32'hC0);
    #1;
    chk("bb1_rdy", {31'd0, lu_ready_o}, 32'd0);
    chk("bb1_cnt", {30'd0, lq_count_o}, 32'd2);
    chk("bb1_a3", {27'd0, a3_o}, 32'd2);
    tick();
    mem_valid_i = 1'b0;
    #1;
    chk("bb2_a3", {27'd0, a3_o}, 32'd3);
    chk("bb2_cnt", {30'd0, lq_count_o}, 32'd2);
    tick();
    chk("bb3_a3", {27'd0, a3_o}, 32'd20);
    chk("bb3_wd", wd3_o, 32'hA0);
    chk("bb3_rdy", {31'd0, lu_ready_o}, 32'd0);
    tick();
    chk("bb4_a3", {27'd0, a3_o}, 32'd21);
    chk("bb4_wd", wd3_o, 32'hB0);
    chk("bb4_cnt", {30'd0, lq_count_o}, 32'd1);
    chk("bb4_rdy", {31'd0, lu_ready_o}, 32'd1);
    tick();
    lu(1'b0, 5'd0, 32'h0);
    #1;
    chk("bb5_a3", {27'd0, a3_o}, 32'd22);
    chk("bb5_wd", wd3_o, 32'hC0);
    chk("bb5_cnt", {30'd0, lq_count_o}, 32'd1);
    tick();
    chk("bb6_cnt", {30'd0, lq_count_o}, 32'd0);
    chk("bb6_we", {31'd0, we3_o}, 32'd0);

    // rd=0 entry is dropped
    lu(1'b1, 5'd0, 32'h55);
    tick();
    lu(1'b0, 5'd0, 32'h0);
    #1;
    chk("x0_cnt", {30'd0, lq_count_o}, 32'd1);
    chk("x0_we", {31'd0, we3_o}, 32'd0);
    tick();
    chk("x0_cnt0", {30'd0, lq_count_o}, 32'd0);

    // flush kills the capture
    mem_op(5'd4, 2'b00, 3'b000, 32'h44, 32'h0, 32'h0);
    flush_i = 1'b1;
    tick();
    mem_valid_i = 1'b0; flush_i = 1'b0;
    #1;
    chk("flush_we", {31'd0, we3_o}, 32'd0);

    // asynchronous reset with a full FIFO and a live pipeline write
    mem_op(5'd1, 2'b00, 3'b000, 32'h1, 32'h0, 32'h0);
    lu(1'b1, 5'd12, 32'h12);
    tick();
    lu(1'b1, 5'd13, 32'h13);
    tick();
    lu(1'b0, 5'd0, 32'h0);
    #1;
    chk("pre_cnt", {30'd0, lq_count_o}, 32'd2);
    chk("pre_we", {31'd0, we3_o}, 32'd1);
    reset_ni = 1'b0;
    #1;
    chk("arst_we", {31'd0, we3_o}, 32'd0);
    chk("arst_cnt", {30'd0, lq_count_o}, 32'd0);
    chk("arst_rdy", {31'd0, lu_ready_o}, 32'd1);
    mem_valid_i = 1'b0;
    #1;
    reset_ni = 1'b1;
    tick();
    chk("post_we", {31'd0, we3_o}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
